// File: rtl/hdmi_rx_frame_writer.sv
// Captures one video frame from the HDMI RX pixel stream into LPDDR2 over Avalon-MM.
// One 32-bit word per pixel at consecutive word addresses from BASE_ADDR; reports done or sync error.
module hdmi_rx_frame_writer #(
  parameter int unsigned       ADDR_W       = 27,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       FRAME_PIXELS = 2073600
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iCAPTURE,
  input  logic              local_init_done,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [23:0]       pix_data,
  output logic              pix_ready,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic [31:0]       avl_writedata,
  output logic              avl_write,
  output logic              avl_burstbegin,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oSYNC_ERR
);

  localparam int unsigned     CntW     = $clog2(FRAME_PIXELS + 1);
  localparam logic [CntW-1:0] FrameCnt = CntW'(FRAME_PIXELS);

  typedef enum logic [1:0] {StIdle, StWaitSof, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                write_q, write_d;
  logic                burst_q, burst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic start, accept, wr_done;

  assign start   = iCAPTURE & local_init_done;
  assign accept  = pix_valid & pix_ready;
  assign wr_done = write_q & avl_waitrequest_n;

  // Ready only when the command register is free or draining this cycle.
  always_comb begin
    pix_ready = 1'b0;
    unique case (state_q)
      StWaitSof: pix_ready = 1'b1;
      StWrite:   pix_ready = (cnt_q < FrameCnt) & (~write_q | avl_waitrequest_n);
      default:   pix_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    burst_d = 1'b0;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWaitSof;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StWaitSof: begin
        if (accept && pix_sof) begin
          state_d = StWrite;
          write_d = 1'b1;
          burst_d = 1'b1;
          addr_d  = BASE_ADDR;
          data_d  = {8'h00, pix_data};
          cnt_d   = CntW'(1);
        end
      end
      StWrite: begin
        if (accept) begin
          write_d = 1'b1;
          burst_d = 1'b1;
          data_d  = {8'h00, pix_data};
          // Any SOF here lands at idx >= 1: resynchronise to the new frame.
          if (pix_sof) begin
            err_d  = 1'b1;
            addr_d = BASE_ADDR;
            cnt_d  = CntW'(1);
          end else begin
            addr_d = BASE_ADDR + ADDR_W'(cnt_q);
            cnt_d  = cnt_q + CntW'(1);
          end
        end else if (wr_done) begin
          write_d = 1'b0;
          if (cnt_q == FrameCnt) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWaitSof) || (state_d == StWrite);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      burst_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      burst_q <= burst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign avl_address    = addr_q;
  assign avl_writedata  = data_q;
  assign avl_write      = write_q;
  assign avl_burstbegin = burst_q;
  assign oBUSY          = busy_q;
  assign oDONE          = done_q;
  assign oSYNC_ERR      = err_q;

endmodule

// File: tb/tb_hdmi_rx_frame_writer.sv
// Directed bench for hdmi_rx_frame_writer: small frames, stalls, early SOF, recapture, reset abort.
module tb_hdmi_rx_frame_writer;

  localparam int unsigned AW   = 27;
  localparam int unsigned FP   = 16;
  localparam logic [26:0] BASE = 27'h100;

  logic          iCLK, iRST_n, iCAPTURE, local_init_done;
  logic          pix_valid, pix_sof, pix_ready;
  logic [23:0]   pix_data;
  logic          avl_waitrequest_n, avl_write, avl_burstbegin;
  logic [AW-1:0] avl_address;
  logic [31:0]   avl_writedata;
  logic          oBUSY, oDONE, oSYNC_ERR;

  hdmi_rx_frame_writer #(
    .ADDR_W      (AW),
    .BASE_ADDR   (BASE),
    .FRAME_PIXELS(FP)
  ) dut (
    .iCLK             (iCLK),
    .iRST_n           (iRST_n),
    .iCAPTURE         (iCAPTURE),
    .local_init_done  (local_init_done),
    .pix_valid        (pix_valid),
    .pix_sof          (pix_sof),
    .pix_data         (pix_data),
    .pix_ready        (pix_ready),
    .avl_waitrequest_n(avl_waitrequest_n),
    .avl_address      (avl_address),
    .avl_writedata    (avl_writedata),
    .avl_write        (avl_write),
    .avl_burstbegin   (avl_burstbegin),
    .oBUSY            (oBUSY),
    .oDONE            (oDONE),
    .oSYNC_ERR        (oSYNC_ERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [23:0] s_data[$];
  bit          s_sof[$];
  logic [26:0] e_addr[$];
  logic [31:0] e_data[$];

  // pre discarded pixels, then a frame; early_at >= 0 re-issues SOF at that frame pixel.
  task automatic build(input int pre, input int early_at, input int tag);
    logic [7:0]  t8;
    logic [7:0]  k8;
    logic [23:0] d;
    int idx, n;
    t8 = tag[7:0];
    s_data.delete(); s_sof.delete(); e_addr.delete(); e_data.delete();
    for (int i = 0; i < pre; i++) begin
      k8 = i[7:0];
      s_data.push_back({t8, 8'h0F, k8});
      s_sof.push_back(1'b0);
    end
    idx = 0;
    n   = (early_at >= 0) ? early_at + FP : FP;
    for (int k = 0; k < n; k++) begin
      k8 = k[7:0];
      d  = {t8, 8'hC0, k8};
      if (k == early_at) idx = 0;
      s_data.push_back(d);
      s_sof.push_back((k == 0) || (k == early_at));
      e_addr.push_back(BASE + 27'(idx));
      e_data.push_back({8'h00, d});
      idx++;
    end
    for (int i = 0; i < 2; i++) begin
      k8 = i[7:0];
      s_data.push_back({t8, 8'hEE, k8});
      s_sof.push_back(1'b0);
    end
  endtask

  // Called at posedge+1 from idle/done.
  task automatic start_capture();
    pix_valid = 1'b0;
    iCAPTURE  = 1'b1;
    @(posedge iCLK); #1;
    iCAPTURE = 1'b0;
    check("cap_busy", oBUSY, 1);
    check("cap_done_clr", oDONE, 0);
    check("cap_err_clr", oSYNC_ERR, 0);
    check("cap_ready", pix_ready, 1);
  endtask

  task automatic run(input int stall_at, input int stall_len, input int cap_at,
                     input int drop_init_at, input bit abort, input bit exp_err);
    int pi, wi, stall_left, last_cyc;
    bit prev_st, done, aborted;
    pi = 0; wi = 0; stall_left = stall_len; last_cyc = -10;
    prev_st = 1'b0; done = 1'b0; aborted = 1'b0;
    for (int cyc = 0; cyc < 200 && !done && !aborted; cyc++) begin
      if (pi < s_data.size()) begin
        pix_valid = 1'b1; pix_sof = s_sof[pi]; pix_data = s_data[pi];
      end else begin
        pix_valid = 1'b0; pix_sof = 1'b0;
      end
      if (avl_write && wi == stall_at && stall_left > 0) begin
        avl_waitrequest_n = 1'b0;
        stall_left--;
      end else begin
        avl_waitrequest_n = 1'b1;
      end
      iCAPTURE = (cyc == cap_at);
      if (cyc == drop_init_at) local_init_done = 1'b0;
      @(negedge iCLK);
      if (oDONE) begin
        check("done_latency", cyc, last_cyc + 1);
        check("write_count", wi, e_addr.size());
        check("pixels_taken", pi, s_data.size() - 2);
        check("busy_at_done", oBUSY, 0);
        check("ready_at_done", pix_ready, 0);
        check("sync_err", oSYNC_ERR, {31'd0, exp_err});
        done = 1'b1;
      end else begin
        check("busy", oBUSY, 1);
        if (avl_write) begin
          if (wi >= e_addr.size()) begin
            check("extra_write", wi, e_addr.size() - 1);
          end else begin
            check("addr", avl_address, e_addr[wi]);
            check("data", avl_writedata, e_data[wi]);
            check("burstbegin", avl_burstbegin, {31'd0, ~prev_st});
          end
          if (!avl_waitrequest_n) check("ready_in_stall", pix_ready, 0);
          if (avl_waitrequest_n) begin
            wi++;
            last_cyc = cyc;
          end
        end else begin
          check("burst_idle", avl_burstbegin, 0);
        end
        prev_st = avl_write & ~avl_waitrequest_n;
        if (pix_valid & pix_ready) pi++;
        if (abort && wi == stall_at && stall_left == stall_len - 2) begin
          #2 iRST_n = 1'b0;
          #1;
          check("rst_write", avl_write, 0);
          check("rst_busy", oBUSY, 0);
          check("rst_ready", pix_ready, 0);
          check("rst_burst", avl_burstbegin, 0);
          aborted = 1'b1;
        end
      end
      if (!aborted) begin
        @(posedge iCLK); #1;
      end
    end
    if (!aborted) check("timeout", {31'd0, done}, 1);
    pix_valid = 1'b0; pix_sof = 1'b0; iCAPTURE = 1'b0;
    avl_waitrequest_n = 1'b1; local_init_done = 1'b1;
  endtask

  initial begin
    // 1: reset with traffic present, then capture without controller ready
    iRST_n = 1'b0; iCAPTURE = 1'b0; local_init_done = 1'b0;
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 24'h123456; avl_waitrequest_n = 1'b1;
    #12;
    check("rst_avl_write", avl_write, 0);
    check("rst_avl_addr", avl_address, 0);
    check("rst_avl_data", avl_writedata, 0);
    check("rst_burstbegin", avl_burstbegin, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_busy", oBUSY, 0);
    check("rst_done", oDONE, 0);
    check("rst_sync_err", oSYNC_ERR, 0);
    @(negedge iCLK); iRST_n = 1'b1;
    @(posedge iCLK); #1;
    iCAPTURE = 1'b1;
    @(posedge iCLK); #1;
    iCAPTURE = 1'b0;
    check("noinit_busy", oBUSY, 0);
    check("noinit_ready", pix_ready, 0);
    @(posedge iCLK); #1;
    check("noinit_write", avl_write, 0);
    pix_valid = 1'b0; pix_sof = 1'b0;
    local_init_done = 1'b1;

    // 2: clean frame after 3 discarded pixels
    build(3, -1, 2);
    start_capture();
    run(-1, 0, -1, -1, 1'b0, 1'b0);

    // 3: 4-cycle stall on write 5
    build(3, -1, 3);
    start_capture();
    run(5, 4, -1, -1, 1'b0, 1'b0);

    // 4: early SOF at frame pixel 7
    build(3, 7, 4);
    start_capture();
    run(-1, 0, -1, -1, 1'b0, 1'b1);

    // 5: capture pulse and init_done drop mid-write, then recapture
    build(2, -1, 5);
    start_capture();
    run(-1, 0, 10, 12, 1'b0, 1'b0);
    build(0, -1, 6);
    start_capture();
    run(-1, 0, -1, -1, 1'b0, 1'b0);

    // 6: reset during a stalled write, then a clean capture
    build(1, -1, 7);
    start_capture();
    run(5, 50, -1, -1, 1'b1, 1'b0);
    @(posedge iCLK); #1;
    check("inrst_busy", oBUSY, 0);
    iRST_n = 1'b1;
    @(posedge iCLK); #1;
    check("post_rst_busy", oBUSY, 0);
    check("post_rst_ready", pix_ready, 0);
    check("post_rst_done", oDONE, 0);
    build(1, -1, 8);
    start_capture();
    run(-1, 0, -1, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
